// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-select
// encodings, FSM state enum and register-address width.
package hazard_ctrl_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int FWD_SEL_WIDTH  = 2;

   localparam logic [FWD_SEL_WIDTH-1:0] FWD_REG = 2'd0;
   localparam logic [FWD_SEL_WIDTH-1:0] FWD_MEM = 2'd1;
   localparam logic [FWD_SEL_WIDTH-1:0] FWD_WB  = 2'd2;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } mc_state_e;

   // The younger producer (MEM) holds the newer value, so it wins over WB.
   function automatic logic [FWD_SEL_WIDTH-1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
      if (mem_hit)
         return FWD_MEM;
      else if (wb_hit)
         return FWD_WB;
      else
         return FWD_REG;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: register addresses and
// enables from ID/EXE/MEM/WB in, forwarding selects and stall/flush controls out.
interface hazard_ctrl_if ();
   import hazard_ctrl_pkg::*;

   logic [REG_ADDR_WIDTH-1:0] rs1_addr_id;
   logic [REG_ADDR_WIDTH-1:0] rs2_addr_id;
   logic                      rs1_used_id;
   logic                      rs2_used_id;
   logic [REG_ADDR_WIDTH-1:0] rs1_addr_exe;
   logic [REG_ADDR_WIDTH-1:0] rs2_addr_exe;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_exe;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_mem;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_wb;
   logic                      rd_wen_exe;
   logic                      rd_wen_mem;
   logic                      rd_wen_wb;
   logic                      mem_read_exe;
   logic                      branch_taken_exe;
   logic                      mc_start;
   logic                      mc_done;

   logic [FWD_SEL_WIDTH-1:0]  fwd_a_sel;
   logic [FWD_SEL_WIDTH-1:0]  fwd_b_sel;
   logic                      stall_if;
   logic                      stall_id;
   logic                      stall_exe;
   logic                      flush_if_id;
   logic                      flush_id_exe;
   logic                      flush_exe_mem;
   logic                      mc_busy;
   logic                      mc_err;

   modport master (
      output rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id,
             rs1_addr_exe, rs2_addr_exe, rd_addr_exe, rd_addr_mem, rd_addr_wb,
             rd_wen_exe, rd_wen_mem, rd_wen_wb, mem_read_exe, branch_taken_exe,
             mc_start, mc_done,
      input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, stall_exe,
             flush_if_id, flush_id_exe, flush_exe_mem, mc_busy, mc_err
   );

   modport slave (
      input  rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id,
             rs1_addr_exe, rs2_addr_exe, rd_addr_exe, rd_addr_mem, rd_addr_wb,
             rd_wen_exe, rd_wen_mem, rd_wen_wb, mem_read_exe, branch_taken_exe,
             mc_start, mc_done,
      output fwd_a_sel, fwd_b_sel, stall_if, stall_id, stall_exe,
             flush_if_id, flush_id_exe, flush_exe_mem, mc_busy, mc_err
   );

endinterface

// File: rtl/hazard_ctrl_hazard_match.sv
// One producer/consumer register compare; x0 and unused sources never match.
module hazard_match
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
   input  logic                      rd_wen,
   input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
   input  logic                      rs_used,
   output logic                      hit
);

   assign hit = rd_wen && rs_used && (rd_addr != '0) && (rd_addr == rs_addr);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: forwarding selects, load-use and branch
// handling, multi-cycle EXE wait FSM with timeout, stall counter.
// Build option: HAZARD_FWD_EN (undefined = interlock instead of forwarding).
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   hazard_ctrl_if.slave         hz,
   output logic [CNT_WIDTH-1:0] perf_stall_cnt
);

   localparam int              TO_W    = $clog2(MC_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

   mc_state_e                 state_reg, state_next;
   logic [TO_W-1:0]           to_cnt_reg, to_cnt_next;
   logic [CNT_WIDTH-1:0]      perf_cnt_reg;

   logic [REG_ADDR_WIDTH-1:0] id_rs  [2];
   logic [REG_ADDR_WIDTH-1:0] exe_rs [2];
   logic [REG_ADDR_WIDTH-1:0] stg_rd [3];
   logic [1:0]                id_used;
   logic [2:0]                stg_wen;
   logic [5:0]                id_hit;   // [src*3 + stage], stage 0=EXE 1=MEM 2=WB
   logic [3:0]                exe_hit;  // [src*2 + stage], stage 0=MEM 1=WB

   logic                      data_hazard;
   logic                      mc_hold;
   logic                      mc_err_next;
   logic [FWD_SEL_WIDTH-1:0]  fwd_a, fwd_b;

   assign id_rs[0]   = hz.rs1_addr_id;
   assign id_rs[1]   = hz.rs2_addr_id;
   assign id_used    = {hz.rs2_used_id, hz.rs1_used_id};
   assign exe_rs[0]  = hz.rs1_addr_exe;
   assign exe_rs[1]  = hz.rs2_addr_exe;
   assign stg_rd[0]  = hz.rd_addr_exe;
   assign stg_rd[1]  = hz.rd_addr_mem;
   assign stg_rd[2]  = hz.rd_addr_wb;
   assign stg_wen    = {hz.rd_wen_wb, hz.rd_wen_mem, hz.rd_wen_exe};

   genvar gi, gj;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         for (gj = 0; gj < 3; gj++) begin : g_id
            hazard_match u_id (
               .rd_addr (stg_rd[gj]),
               .rd_wen  (stg_wen[gj]),
               .rs_addr (id_rs[gi]),
               .rs_used (id_used[gi]),
               .hit     (id_hit[gi*3 + gj])
            );
         end
         // EXE operands are always read, so the used flag is tied high.
         for (gj = 0; gj < 2; gj++) begin : g_fwd
            hazard_match u_fwd (
               .rd_addr (stg_rd[gj+1]),
               .rd_wen  (stg_wen[gj+1]),
               .rs_addr (exe_rs[gi]),
               .rs_used (1'b1),
               .hit     (exe_hit[gi*2 + gj])
            );
         end
      end
   endgenerate

`ifdef HAZARD_FWD_EN
   logic unused_fwd_bits;
   assign unused_fwd_bits = ^{id_hit[5:4], id_hit[2:1]};
   assign fwd_a       = fwd_pick(exe_hit[0], exe_hit[1]);
   assign fwd_b       = fwd_pick(exe_hit[2], exe_hit[3]);
   assign data_hazard = hz.mem_read_exe && (id_hit[0] || id_hit[3]);
`else
   // Without bypass paths the consumer waits in ID until the producer retires.
   logic unused_fwd_bits;
   assign unused_fwd_bits = ^{exe_hit, hz.mem_read_exe};
   assign fwd_a       = FWD_REG;
   assign fwd_b       = FWD_REG;
   assign data_hazard = |id_hit;
`endif

   always_comb begin
      state_next  = state_reg;
      to_cnt_next = to_cnt_reg;
      mc_hold     = 1'b0;
      mc_err_next = 1'b0;
      case (state_reg)
         RUN: begin
            if (hz.mc_start && !hz.branch_taken_exe) begin
               state_next  = MC_WAIT;
               to_cnt_next = '0;
            end
         end
         MC_WAIT: begin
            if (hz.mc_done) begin
               state_next = RUN;
            end else if (to_cnt_reg == TO_LAST) begin
               mc_err_next = 1'b1;
               state_next  = RUN;
            end else begin
               mc_hold     = 1'b1;
               to_cnt_next = to_cnt_reg + TO_W'(1);
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      hz.stall_if      = 1'b0;
      hz.stall_id      = 1'b0;
      hz.stall_exe     = 1'b0;
      hz.flush_if_id   = 1'b0;
      hz.flush_id_exe  = 1'b0;
      hz.flush_exe_mem = 1'b0;
      if (mc_hold) begin
         hz.stall_if      = 1'b1;
         hz.stall_id      = 1'b1;
         hz.stall_exe     = 1'b1;
         hz.flush_exe_mem = 1'b1;
      end else if (hz.branch_taken_exe) begin
         hz.flush_if_id  = 1'b1;
         hz.flush_id_exe = 1'b1;
      end else if (data_hazard) begin
         hz.stall_if     = 1'b1;
         hz.stall_id     = 1'b1;
         hz.flush_id_exe = 1'b1;
      end
   end

   assign hz.fwd_a_sel = fwd_a;
   assign hz.fwd_b_sel = fwd_b;
   assign hz.mc_busy   = mc_hold;
   assign hz.mc_err    = mc_err_next;
   assign perf_stall_cnt = perf_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= RUN;
         to_cnt_reg   <= '0;
         perf_cnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         to_cnt_reg <= to_cnt_next;
         if (hz.stall_if && (perf_cnt_reg != '1))
            perf_cnt_reg <= perf_cnt_reg + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the combinational rules
// plus hand sequences for load-use counting, multi-cycle wait, timeout and reset.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] perf;
   int          n_cmp = 0;
   int          n_mis = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if hz_bus ();

   hazard_ctrl #(.MC_TIMEOUT(8), .CNT_WIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .hz             (hz_bus),
      .perf_stall_cnt (perf)
   );

   typedef struct {
      logic [4:0] rs1_id, rs2_id;
      logic       u1, u2;
      logic [4:0] rs1_exe, rs2_exe, rd_exe, rd_mem, rd_wb;
      logic       w_exe, w_mem, w_wb, ld, br;
      logic [1:0] ea, eb;      // expected selects with forwarding built in
      logic       st_f, st_n;  // expected stall with / without forwarding
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      hz_bus.rs1_addr_id = '0;      hz_bus.rs2_addr_id = '0;
      hz_bus.rs1_used_id = 1'b0;    hz_bus.rs2_used_id = 1'b0;
      hz_bus.rs1_addr_exe = '0;     hz_bus.rs2_addr_exe = '0;
      hz_bus.rd_addr_exe = '0;      hz_bus.rd_addr_mem = '0;
      hz_bus.rd_addr_wb = '0;       hz_bus.rd_wen_exe = 1'b0;
      hz_bus.rd_wen_mem = 1'b0;     hz_bus.rd_wen_wb = 1'b0;
      hz_bus.mem_read_exe = 1'b0;   hz_bus.branch_taken_exe = 1'b0;
      hz_bus.mc_start = 1'b0;       hz_bus.mc_done = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      hz_bus.rs1_addr_id = v.rs1_id;    hz_bus.rs2_addr_id = v.rs2_id;
      hz_bus.rs1_used_id = v.u1;        hz_bus.rs2_used_id = v.u2;
      hz_bus.rs1_addr_exe = v.rs1_exe;  hz_bus.rs2_addr_exe = v.rs2_exe;
      hz_bus.rd_addr_exe = v.rd_exe;    hz_bus.rd_addr_mem = v.rd_mem;
      hz_bus.rd_addr_wb = v.rd_wb;      hz_bus.rd_wen_exe = v.w_exe;
      hz_bus.rd_wen_mem = v.w_mem;      hz_bus.rd_wen_wb = v.w_wb;
      hz_bus.mem_read_exe = v.ld;       hz_bus.branch_taken_exe = v.br;
      hz_bus.mc_start = 1'b0;           hz_bus.mc_done = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      idle();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       st;
      logic [3:0] p_st;
      logic [1:0] p_a [4];

      //          rs1i  rs2i  u1 u2 rs1e  rs2e  rde   rdm   rdw   we wm ww ld br  ea       eb       stf stn
      vecs[0]  = '{5'd1, 5'd2, 1, 1, 5'd5, 5'd6, 5'd9, 5'd5, 5'd5, 1, 1, 1, 0, 0, FWD_MEM, FWD_REG, 0, 0};
      vecs[1]  = '{5'd1, 5'd2, 1, 1, 5'd5, 5'd6, 5'd9, 5'd0, 5'd5, 1, 1, 1, 0, 0, FWD_WB,  FWD_REG, 0, 0};
      vecs[2]  = '{5'd1, 5'd2, 1, 1, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, FWD_REG, FWD_REG, 0, 0};
      vecs[3]  = '{5'd1, 5'd2, 1, 1, 5'd5, 5'd5, 5'd9, 5'd5, 5'd5, 1, 0, 1, 0, 0, FWD_WB,  FWD_WB,  0, 0};
      vecs[4]  = '{5'd1, 5'd2, 1, 1, 5'd4, 5'd4, 5'd9, 5'd4, 5'd4, 1, 1, 1, 0, 0, FWD_MEM, FWD_MEM, 0, 0};
      vecs[5]  = '{5'd1, 5'd7, 1, 1, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1, 1, 1, 1, 0, FWD_REG, FWD_REG, 1, 1};
      vecs[6]  = '{5'd1, 5'd7, 1, 0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1, 1, 1, 1, 0, FWD_REG, FWD_REG, 0, 0};
      vecs[7]  = '{5'd0, 5'd0, 1, 1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 1, 1, 0, FWD_REG, FWD_REG, 0, 0};
      vecs[8]  = '{5'd1, 5'd7, 1, 1, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1, 1, 1, 1, 1, FWD_REG, FWD_REG, 0, 0};
      vecs[9]  = '{5'd7, 5'd2, 1, 1, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1, 1, 1, 0, 0, FWD_REG, FWD_REG, 0, 1};
      vecs[10] = '{5'd3, 5'd2, 1, 1, 5'd0, 5'd0, 5'd9, 5'd0, 5'd3, 1, 1, 1, 0, 0, FWD_REG, FWD_REG, 0, 1};
      vecs[11] = '{5'd3, 5'd2, 1, 1, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1, 0, 1, 0, 0, FWD_REG, FWD_REG, 0, 0};
      vecs[12] = '{5'd3, 5'd2, 1, 1, 5'd3, 5'd0, 5'd3, 5'd0, 5'd0, 1, 1, 1, 0, 1, FWD_REG, FWD_REG, 0, 0};

      // Reset state with idle inputs.
      reset_dut();
      #1;
      chk("rst.fwd_a", hz_bus.fwd_a_sel, FWD_REG);
      chk("rst.fwd_b", hz_bus.fwd_b_sel, FWD_REG);
      chk("rst.stall_if", hz_bus.stall_if, 0);
      chk("rst.stall_exe", hz_bus.stall_exe, 0);
      chk("rst.flush_id_exe", hz_bus.flush_id_exe, 0);
      chk("rst.mc_busy", hz_bus.mc_busy, 0);
      chk("rst.mc_err", hz_bus.mc_err, 0);
      chk("rst.perf", perf, 0);

      // Single load-use bubble advances the stall counter from 0 to 1.
      apply(vecs[5]);
      #1;
      chk("lu.stall_if", hz_bus.stall_if, 1);
      chk("lu.flush_id_exe", hz_bus.flush_id_exe, 1);
      tick();
      idle();
      #1;
      chk("lu.stall_if_after", hz_bus.stall_if, 0);
      chk("lu.perf", perf, 1);
      $display("load-use: perf_stall_cnt=%0d", perf);

      // Combinational rule table.
      for (int i = 0; i < 13; i++) begin
         tick();
         apply(vecs[i]);
         #1;
`ifdef HAZARD_FWD_EN
         st = vecs[i].st_f;
         chk($sformatf("v%0d.fwd_a", i), hz_bus.fwd_a_sel, vecs[i].ea);
         chk($sformatf("v%0d.fwd_b", i), hz_bus.fwd_b_sel, vecs[i].eb);
`else
         st = vecs[i].st_n;
         chk($sformatf("v%0d.fwd_a", i), hz_bus.fwd_a_sel, FWD_REG);
         chk($sformatf("v%0d.fwd_b", i), hz_bus.fwd_b_sel, FWD_REG);
`endif
         chk($sformatf("v%0d.stall_if", i), hz_bus.stall_if, st);
         chk($sformatf("v%0d.stall_id", i), hz_bus.stall_id, st);
         chk($sformatf("v%0d.stall_exe", i), hz_bus.stall_exe, 0);
         chk($sformatf("v%0d.flush_if_id", i), hz_bus.flush_if_id, vecs[i].br);
         chk($sformatf("v%0d.flush_id_exe", i), hz_bus.flush_id_exe, st | vecs[i].br);
         $display("vec %0d: fwd_a=%0d fwd_b=%0d stall_if=%0b flush_if_id=%0b flush_id_exe=%0b",
                  i, hz_bus.fwd_a_sel, hz_bus.fwd_b_sel, hz_bus.stall_if,
                  hz_bus.flush_if_id, hz_bus.flush_id_exe);
      end

      // Multi-cycle op completing after 5 wait cycles.
      reset_dut();
      hz_bus.mc_start = 1'b1;
      #1;
      chk("mc.start_busy", hz_bus.mc_busy, 0);
      tick();
      hz_bus.mc_start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk($sformatf("mc.c%0d.busy", k), hz_bus.mc_busy, 1);
         chk($sformatf("mc.c%0d.stall_if", k), hz_bus.stall_if, 1);
         chk($sformatf("mc.c%0d.stall_exe", k), hz_bus.stall_exe, 1);
         chk($sformatf("mc.c%0d.flush_exe_mem", k), hz_bus.flush_exe_mem, 1);
         chk($sformatf("mc.c%0d.err", k), hz_bus.mc_err, 0);
         tick();
      end
      hz_bus.mc_done = 1'b1;
      #1;
      chk("mc.done.stall_if", hz_bus.stall_if, 0);
      chk("mc.done.busy", hz_bus.mc_busy, 0);
      chk("mc.done.err", hz_bus.mc_err, 0);
      tick();
      hz_bus.mc_done = 1'b0;
      #1;
      chk("mc.after.busy", hz_bus.mc_busy, 0);
      chk("mc.perf", perf, 4);
      $display("mc done: released, perf_stall_cnt=%0d", perf);

      // Timeout with MC_TIMEOUT=8: error pulse in wait cycle 8.
      reset_dut();
      hz_bus.mc_start = 1'b1;
      tick();
      hz_bus.mc_start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         #1;
         chk($sformatf("to.c%0d.err", k), hz_bus.mc_err, (k == 8) ? 1 : 0);
         chk($sformatf("to.c%0d.busy", k), hz_bus.mc_busy, (k < 8) ? 1 : 0);
         tick();
      end
      $display("timeout: perf_stall_cnt=%0d", perf);
      chk("to.perf", perf, 7);

      // Done arriving in the timeout cycle suppresses the error.
      reset_dut();
      hz_bus.mc_start = 1'b1;
      tick();
      hz_bus.mc_start = 1'b0;
      repeat (7) tick();
      hz_bus.mc_done = 1'b1;
      #1;
      chk("dt.err", hz_bus.mc_err, 0);
      chk("dt.stall_if", hz_bus.stall_if, 0);
      tick();
      hz_bus.mc_done = 1'b0;
      #1;
      chk("dt.after.busy", hz_bus.mc_busy, 0);
      $display("done+timeout: mc_err=%0b", hz_bus.mc_err);

      // Reset in wait cycle 4 abandons the op silently.
      reset_dut();
      hz_bus.mc_start = 1'b1;
      tick();
      hz_bus.mc_start = 1'b0;
      repeat (3) tick();
      #1;
      chk("rw.pre.busy", hz_bus.mc_busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk($sformatf("rw.c%0d.err", k), hz_bus.mc_err, 0);
         chk($sformatf("rw.c%0d.busy", k), hz_bus.mc_busy, 0);
         tick();
      end
      chk("rw.perf", perf, 0);
      $display("reset in wait: perf_stall_cnt=%0d", perf);

      // ALU producer rd=3 flows EXE->MEM->WB while ID reads rs1=3.
`ifdef HAZARD_FWD_EN
      p_st = 4'b0000;
      p_a[0] = FWD_REG; p_a[1] = FWD_MEM; p_a[2] = FWD_WB; p_a[3] = FWD_REG;
`else
      p_st = 4'b0111;
      p_a[0] = FWD_REG; p_a[1] = FWD_REG; p_a[2] = FWD_REG; p_a[3] = FWD_REG;
`endif
      reset_dut();
      for (int k = 0; k < 4; k++) begin
         idle();
         hz_bus.rs1_addr_id  = 5'd3;
         hz_bus.rs1_used_id  = 1'b1;
         hz_bus.rs1_addr_exe = 5'd3;
         if (k == 0) begin hz_bus.rd_addr_exe = 5'd3; hz_bus.rd_wen_exe = 1'b1; end
         if (k == 1) begin hz_bus.rd_addr_mem = 5'd3; hz_bus.rd_wen_mem = 1'b1; end
         if (k == 2) begin hz_bus.rd_addr_wb  = 5'd3; hz_bus.rd_wen_wb  = 1'b1; end
         #1;
         chk($sformatf("raw.c%0d.stall_if", k), hz_bus.stall_if, p_st[k]);
         chk($sformatf("raw.c%0d.fwd_a", k), hz_bus.fwd_a_sel, p_a[k]);
         $display("raw cycle %0d: stall_if=%0b fwd_a=%0d", k, hz_bus.stall_if, hz_bus.fwd_a_sel);
         tick();
      end
      idle();
      #1;
`ifdef HAZARD_FWD_EN
      chk("raw.perf", perf, 0);
`else
      chk("raw.perf", perf, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
